// File: rtl/vecmac_pkg.sv
// Shared state encodings and default widths for the vecmac dot-product sequencer.
package vecmac_pkg;
  localparam int LEN_W_DEF = 8;
  localparam int ACC_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/vecmac_acc.sv
// Dot-product accumulator with sticky overflow; define VECMAC_SAT_EN to clamp on
// overflow, otherwise the sum wraps and ovf is tied low.
module vecmac_acc #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add_en,
  input  logic [15:0]      addend,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);
  logic [ACC_W-1:0] r_acc;

`ifdef VECMAC_SAT_EN
  logic [ACC_W:0] w_sum;
  logic           r_ovf;

  assign w_sum = (ACC_W+1)'(r_acc) + (ACC_W+1)'(addend);

  // Once clamped, the accumulator stays at all-ones until the next job clears it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (add_en) begin
      r_ovf <= r_ovf | w_sum[ACC_W];
      if (r_ovf || w_sum[ACC_W]) r_acc <= '1;
      else                       r_acc <= w_sum[ACC_W-1:0];
    end
  end

  assign ovf = r_ovf;
`else
  logic [ACC_W-1:0] w_sum;

  assign w_sum = r_acc + ACC_W'(addend);

  always_ff @(posedge clk) begin
    if (rst || clr) r_acc <= '0;
    else if (add_en) r_acc <= w_sum;
  end

  assign ovf = 1'b0;
`endif

  assign acc = r_acc;
endmodule

// File: rtl/vecmac_ctrl.sv
// Sequencer for one INT8 dot-product job on an external 3-stage multiplier.
// Overflow handling follows VECMAC_SAT_EN (saturate) or its absence (wrap, res_ovf=0).
module vecmac_ctrl
  import vecmac_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic             mul_in_valid,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic             mul_out_valid,
  input  logic [15:0]      mul_product,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf
);
  state_e           r_state, w_state_next;
  logic [LEN_W-1:0] r_len, r_iss_cnt, r_ret_cnt;
  logic [LEN_W-1:0] w_iss_inc, w_ret_inc;
  logic             w_job_start, w_op_fire, w_ret_fire;

  assign w_job_start = (r_state == ST_IDLE) && start;
  assign w_op_fire   = op_valid && op_ready;
  // Products arriving outside a job are stale and must not touch the accumulator.
  assign w_ret_fire  = mul_out_valid && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
  assign w_iss_inc   = r_iss_cnt + LEN_W'(1);
  assign w_ret_inc   = r_ret_cnt + LEN_W'(1);

  assign busy         = (r_state != ST_IDLE);
  assign op_ready     = (r_state == ST_ISSUE);
  assign res_valid    = (r_state == ST_DONE);
  assign mul_in_valid = w_op_fire;
  assign mul_a        = op_a;
  assign mul_b        = op_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_iss_cnt <= '0;
      r_ret_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_job_start) begin
        r_len     <= len;
        r_iss_cnt <= '0;
        r_ret_cnt <= '0;
      end else begin
        if (w_op_fire)  r_iss_cnt <= w_iss_inc;
        if (w_ret_fire) r_ret_cnt <= w_ret_inc;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = (len == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_op_fire && (w_iss_inc == r_len)) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_ret_fire && (w_ret_inc == r_len)) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  vecmac_acc #(
    .ACC_W(ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_job_start),
    .add_en (w_ret_fire),
    .addend (mul_product),
    .acc    (res_data),
    .ovf    (res_ovf)
  );
endmodule

// File: tb/tb_vecmac_ctrl.sv
// Directed bench for vecmac_ctrl with a behavioural 3-stage multiplier pipeline.
module tb_vecmac_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start16 = 1'b0;
  logic        op_valid = 1'b0, res_ready = 1'b0;
  logic [7:0]  len = 8'd0, op_a = 8'd0, op_b = 8'd0;

  logic        busy, op_ready, miv, res_valid, res_ovf;
  logic [7:0]  mul_a, mul_b;
  logic [23:0] res_data;
  logic        busy16, op_ready16, miv16, res_valid16, res_ovf16;
  logic [7:0]  mul_a16, mul_b16;
  logic [15:0] res_data16;

  logic        mul_out_valid;
  logic [15:0] mul_product;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vecmac_ctrl #(.LEN_W(8), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mul_in_valid(miv), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out_valid(mul_out_valid), .mul_product(mul_product),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf)
  );

  vecmac_ctrl #(.LEN_W(8), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .len(len), .busy(busy16),
    .op_valid(op_valid), .op_ready(op_ready16), .op_a(op_a), .op_b(op_b),
    .mul_in_valid(miv16), .mul_a(mul_a16), .mul_b(mul_b16),
    .mul_out_valid(mul_out_valid), .mul_product(mul_product),
    .res_valid(res_valid16), .res_ready(res_ready), .res_data(res_data16), .res_ovf(res_ovf16)
  );

  // Only one controller is ever busy, so both share a single multiplier model.
  logic       w_miv;
  logic [7:0] w_pa, w_pb;
  logic [2:0] r_pv;
  logic [15:0] r_pp0, r_pp1, r_pp2;
  assign w_miv = miv | miv16;
  assign w_pa  = miv16 ? mul_a16 : mul_a;
  assign w_pb  = miv16 ? mul_b16 : mul_b;
  always_ff @(posedge clk) begin
    if (rst) r_pv <= 3'b000;
    else     r_pv <= {r_pv[1:0], w_miv};
    r_pp0 <= 16'(w_pa) * 16'(w_pb);
    r_pp1 <= r_pp0;
    r_pp2 <= r_pp1;
  end
  assign mul_out_valid = r_pv[2];
  assign mul_product   = r_pp2;

  typedef struct {
    logic [7:0]  len;
    logic [31:0] a;
    logic [31:0] b;
    int          gap;
    logic [23:0] exp_data;
    int          exp_lat;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic rv(input bit sel);
    return sel ? res_valid16 : res_valid;
  endfunction

  // Runs one job; lat counts cycles from the last handshake cycle (cycle 0) to res_valid.
  task automatic run_job(input bit sel, input logic [7:0] ln, input logic [31:0] apk,
                         input logic [31:0] bpk, input int gap,
                         output logic [23:0] d, output logic ov, output int lat, output int pulses);
    int  i;
    int  waits;
    bit  hs;
    pulses = 0;
    i = 0;
    waits = 0;
    len = ln;
    if (sel) start16 = 1'b1; else start = 1'b1;
    step();
    start = 1'b0;
    start16 = 1'b0;
    while (i < int'(ln) && waits < 200) begin
      op_a = apk[8*i +: 8];
      op_b = bpk[8*i +: 8];
      op_valid = 1'b1;
      #1;
      hs = w_miv;
      if (hs) begin
        pulses++;
        i++;
      end
      step();
      waits++;
      op_valid = 1'b0;
      if (hs && i < int'(ln)) begin
        repeat (gap) begin
          #1;
          if (w_miv) pulses++;
          step();
        end
      end
    end
    if (i < int'(ln)) check("issue_timeout", i, ln);
    lat = 1;
    while (!rv(sel) && lat < 40) begin
      #1;
      if (w_miv) pulses++;
      step();
      lat++;
    end
    d  = sel ? {8'd0, res_data16} : res_data;
    ov = sel ? res_ovf16 : res_ovf;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  vec_t        vecs[5];
  logic [23:0] d;
  logic        ov;
  int          lat, pulses, n;

  initial begin
    vecs[0] = '{8'd4, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0, 24'd70, 4};
    vecs[1] = '{8'd3, 32'h00FF_FFFF, 32'h00FF_FFFF, 2, 24'd195075, 4};
    vecs[2] = '{8'd0, 32'd0, 32'd0, 0, 24'd0, 1};
    vecs[3] = '{8'd2, {16'd0, 8'd200, 8'd10}, {16'd0, 8'd100, 8'd20}, 1, 24'd20200, 4};
    vecs[4] = '{8'd1, 32'd255, 32'd1, 0, 24'd255, 4};

    rst = 1'b1;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_ovf", res_ovf, 0);
    check("rst_busy16", busy16, 0);
    check("rst_res_data16", res_data16, 0);
    rst = 1'b0;
    step();

    for (int k = 0; k < 5; k++) begin
      run_job(1'b0, vecs[k].len, vecs[k].a, vecs[k].b, vecs[k].gap, d, ov, lat, pulses);
      $display("job %0d: len=%0d gap=%0d data=%0d ovf=%0d lat=%0d pulses=%0d",
               k, vecs[k].len, vecs[k].gap, d, ov, lat, pulses);
      check($sformatf("vec%0d_data", k), d, vecs[k].exp_data);
      check($sformatf("vec%0d_ovf", k), ov, 0);
      check($sformatf("vec%0d_latency", k), lat, vecs[k].exp_lat);
      check($sformatf("vec%0d_mul_pulses", k), pulses, vecs[k].len);
      check($sformatf("vec%0d_idle_after_ack", k), busy, 0);
    end

    // Held result under consumer backpressure, with a start pulse that must be ignored.
    len = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    op_a = 8'd2;
    op_b = 8'd3;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    check("hold_reach_done", res_valid, 1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        start = 1'b1;
        len = 8'd5;
      end else begin
        start = 1'b0;
      end
      step();
      check($sformatf("hold%0d_res_valid", k), res_valid, 1);
      check($sformatf("hold%0d_res_data", k), res_data, 6);
      check($sformatf("hold%0d_busy", k), busy, 1);
    end
    start = 1'b0;
    $display("hold: res_data=%0d held 5 cycles", res_data);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("hold_idle_busy", busy, 0);
    check("hold_idle_res_valid", res_valid, 0);
    step();
    check("hold_start_ignored", busy, 0);

    // Reset in the middle of a job with products still in the multiplier.
    len = 8'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      op_a = 8'd100;
      op_b = 8'd100;
      op_valid = 1'b1;
      step();
    end
    op_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_op_ready", op_ready, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_res_data", res_data, 0);
    check("midrst_res_ovf", res_ovf, 0);
    run_job(1'b0, 8'd1, 32'd3, 32'd3, 0, d, ov, lat, pulses);
    $display("post-reset job: data=%0d lat=%0d pulses=%0d", d, lat, pulses);
    check("midrst_job_data", d, 9);
    check("midrst_job_latency", lat, 4);
    check("midrst_job_pulses", pulses, 1);

    // 16-bit accumulator overflow.
    run_job(1'b1, 8'd2, 32'h0000_FFFF, 32'h0000_FFFF, 0, d, ov, lat, pulses);
    $display("acc16 job: data=%0d ovf=%0d lat=%0d", d, ov, lat);
`ifdef VECMAC_SAT_EN
    check("ovf16_data", d, 24'h00FFFF);
    check("ovf16_flag", ov, 1);
`else
    check("ovf16_data", d, 24'd64514);
    check("ovf16_flag", ov, 0);
`endif
    check("ovf16_latency", lat, 4);
    check("ovf16_idle", busy16, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
